rom_window_sequencer: RTL and testbench

Sequencing controller for the dual-port combinational image ROM (64x64 pixels, 12-bit address, 13-bit data). On `start` it raster-scans the image and, for every pixel, fetches the 3x3 neighbourhood two taps per cycle through both ROM ports, with zero padding at the borders. It presents each assembled window on a valid/ready stream to the downstream convolution kernels.

---
 rtl/rom_window_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_rom_window_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_window_sequencer.sv
// rom_window_sequencer: raster-scans a dual-port image ROM and assembles a
// zero-padded 3x3 window per pixel, two taps per cycle. Each window is
// presented on a valid/ready stream.
module rom_window_sequencer #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 13
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_W-1:0]          rom_addr1,
    output logic [ADDR_W-1:0]          rom_addr2,
    input  logic [DATA_W-1:0]          rom_data1,
    input  logic [DATA_W-1:0]          rom_data2,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [9*DATA_W-1:0]        win_data,
    output logic [$clog2(IMG_W)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
    output logic                       win_last
);

    localparam int CW = $clog2(IMG_W);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;

    // Signed coordinate limits; one extra bit each side absorbs the -1/+1 offsets
    localparam logic signed [CW+1:0] H_S = (CW+2)'(IMG_H);
    localparam logic signed [CW+1:0] W_S = (CW+2)'(IMG_W);
    localparam logic signed [CW+1:0] ONE = (CW+2)'(1);

    logic [1:0]    state_q, state_d;
    logic [2:0]    f_q, f_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          busy_d, done_d, valid_d, last_d;
    logic          last_pos;

    logic [3:0]        k1, k2;
    logic [ADDR_W:0]   lk1, lk2;
    logic              pad1, pad2, cap2;

    // Returns {pad, addr} for tap k around centre (r, c); padding taps address 0
    function automatic logic [ADDR_W:0] tap_lookup(input logic [3:0]    k,
                                                   input logic [CW-1:0] r,
                                                   input logic [CW-1:0] c);
        logic signed [CW+1:0] dr, dc, rr, cc;
        logic [ADDR_W-1:0]    addr;
        case (k)
            4'd0, 4'd1, 4'd2: dr = '1;
            4'd3, 4'd4, 4'd5: dr = '0;
            default:          dr = ONE;
        endcase
        case (k)
            4'd0, 4'd3, 4'd6: dc = '1;
            4'd1, 4'd4, 4'd7: dc = '0;
            default:          dc = ONE;
        endcase
        rr = $signed({2'b00, r}) + dr;
        cc = $signed({2'b00, c}) + dc;
        if (rr < 0 || rr >= H_S || cc < 0 || cc >= W_S) begin
            tap_lookup = {1'b1, {ADDR_W{1'b0}}};
        end else begin
            addr = (ADDR_W'(rr) << CW) | ADDR_W'(cc[CW-1:0]);
            tap_lookup = {1'b0, addr};
        end
    endfunction

    // Tap selection and ROM address decode from the registered scan position
    always_comb begin
        k1   = {f_q, 1'b0};
        k2   = {f_q, 1'b1};
        cap2 = (f_q != 3'd4);
        lk1  = tap_lookup(k1, row_q, col_q);
        lk2  = tap_lookup(k2, row_q, col_q);
        pad1 = lk1[ADDR_W];
        pad2 = lk2[ADDR_W];
        rom_addr1 = '0;
        rom_addr2 = '0;
        if (state_q == S_FETCH) begin
            rom_addr1 = lk1[ADDR_W-1:0];
            if (cap2) begin
                rom_addr2 = lk2[ADDR_W-1:0];
            end
        end
    end

    // Sequencer next-state: fetch five tap pairs, present, advance raster position
    always_comb begin
        state_d  = state_q;
        f_d      = f_q;
        row_d    = row_q;
        col_d    = col_q;
        done_d   = 1'b0;
        last_pos = (row_q == CW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    f_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_FETCH: begin
                if (f_q == 3'd4) begin
                    state_d = S_PRESENT;
                end else begin
                    f_d = f_q + 3'd1;
                end
            end
            S_PRESENT: begin
                if (win_ready) begin
                    if (last_pos) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        f_d     = '0;
                        col_d   = col_q + CW'(1);
                        if (col_q == CW'(IMG_W - 1)) begin
                            row_d = row_q + CW'(1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_PRESENT);
        // Position does not move between fetch and present, so last is known on entry
        last_d  = (state_d == S_PRESENT) && last_pos;
    end

    // Control state and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            f_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            state_q   <= state_d;
            f_q       <= f_d;
            row_q     <= row_d;
            col_q     <= col_d;
            busy      <= busy_d;
            done      <= done_d;
            win_valid <= valid_d;
            win_last  <= last_d;
        end
    end

    // Capture the two fetched taps; every tap is rewritten each window, so no clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_data <= '0;
        end else if (state_q == S_FETCH) begin
            for (int k = 0; k < 9; k++) begin
                if (k1 == 4'(k)) begin
                    win_data[k*DATA_W +: DATA_W] <= pad1 ? '0 : rom_data1;
                end else if (cap2 && (k2 == 4'(k))) begin
                    win_data[k*DATA_W +: DATA_W] <= pad2 ? '0 : rom_data2;
                end
            end
        end
    end

    assign win_row = row_q;
    assign win_col = col_q;

endmodule

// File: tb/tb_rom_window_sequencer.sv
// Self-checking bench for rom_window_sequencer: a cycle-level behavioural
// model of the scan plus hand-computed windows for a data=address ROM.
module tb_rom_window_sequencer;

    localparam int W  = 64;
    localparam int H  = 64;
    localparam int AW = 12;
    localparam int DW = 13;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              win_ready = 1'b0;
    logic              busy, done, win_valid, win_last;
    logic [AW-1:0]     rom_addr1, rom_addr2;
    logic [DW-1:0]     rom_data1, rom_data2;
    logic [9*DW-1:0]   win_data;
    logic [5:0]        win_row, win_col;

    logic [DW-1:0]     rom_mem [W*H];

    assign rom_data1 = rom_mem[rom_addr1];
    assign rom_data2 = rom_mem[rom_addr2];

    rom_window_sequencer #(
        .IMG_W (W),
        .IMG_H (H),
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rom_addr1(rom_addr1),
        .rom_addr2(rom_addr2),
        .rom_data1(rom_data1),
        .rom_data2(rom_data2),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .win_data (win_data),
        .win_row  (win_row),
        .win_col  (win_col),
        .win_last (win_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Model state: mode 0 idle, 1 fetch, 2 present
    int   m_mode = 0;
    int   m_f = 0;
    int   m_r = 0;
    int   m_c = 0;
    logic m_done = 1'b0;
    int   hs_count = 0;
    int   scan_windows = -1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Linear address of tap k around (r, c), or -1 when the tap falls off the image
    function automatic int tap_addr(input int r, input int c, input int k);
        int rr, cc;
        rr = r + k / 3 - 1;
        cc = c + k % 3 - 1;
        if (rr < 0 || rr >= H || cc < 0 || cc >= W) return -1;
        return rr * W + cc;
    endfunction

    function automatic logic [AW-1:0] exp_addr(input int r, input int c, input int k);
        int a;
        a = tap_addr(r, c, k);
        return (a < 0) ? '0 : AW'(a);
    endfunction

    function automatic logic [9*DW-1:0] exp_window(input int r, input int c);
        logic [9*DW-1:0] w;
        int a;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            a = tap_addr(r, c, k);
            w[k*DW +: DW] = (a < 0) ? '0 : rom_mem[a];
        end
        return w;
    endfunction

    task automatic check_taps(input string name, input int t[9]);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("%s tap%0d", name, k), 128'(win_data[k*DW +: DW]), 128'(t[k]));
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " busy"}, 128'(busy), 0);
        check({tag, " done"}, 128'(done), 0);
        check({tag, " valid"}, 128'(win_valid), 0);
        check({tag, " last"}, 128'(win_last), 0);
        check({tag, " data"}, 128'(win_data), 0);
        check({tag, " row"}, 128'(win_row), 0);
        check({tag, " col"}, 128'(win_col), 0);
        check({tag, " addr1"}, 128'(rom_addr1), 0);
        check({tag, " addr2"}, 128'(rom_addr2), 0);
    endtask

    // Wait (bounded) for window (r, c) to be presented; returns at that negedge
    task automatic wait_win(input int r, input int c, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (win_valid && win_row == 6'(r) && win_col == 6'(c)) begin
                checks++;
                return;
            end
        end
        checks++;
        fails++;
        $display("FAIL wait_win(%0d,%0d): window never presented within %0d cycles", r, c, bound);
    endtask

    // Compare process: checks every output against the model each cycle, then steps the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check_reset("in reset");
                m_mode = 0;
                m_done = 1'b0;
            end else begin
                check("done", 128'(done), 128'(m_done));
                check("busy", 128'(busy), 128'(m_mode != 0));
                check("valid", 128'(win_valid), 128'(m_mode == 2));
                if (m_mode == 1) begin
                    check("addr1", 128'(rom_addr1), 128'(exp_addr(m_r, m_c, 2 * m_f)));
                    check("addr2", 128'(rom_addr2),
                          (m_f == 4) ? 128'(0) : 128'(exp_addr(m_r, m_c, 2 * m_f + 1)));
                end else begin
                    check("addr1 idle", 128'(rom_addr1), 0);
                    check("addr2 idle", 128'(rom_addr2), 0);
                end
                if (m_mode == 2) begin
                    check("win_data", 128'(win_data), 128'(exp_window(m_r, m_c)));
                    check("win_row", 128'(win_row), 128'(m_r));
                    check("win_col", 128'(win_col), 128'(m_c));
                    check("win_last", 128'(win_last), 128'(m_r == H - 1 && m_c == W - 1));
                end
                case (m_mode)
                    0: begin
                        m_done = 1'b0;
                        if (start) begin
                            m_mode = 1;
                            m_f = 0;
                            m_r = 0;
                            m_c = 0;
                            hs_count = 0;
                        end
                    end
                    1: begin
                        if (m_f == 4) m_mode = 2;
                        else m_f++;
                    end
                    default: begin
                        if (win_ready) begin
                            hs_count++;
                            if (m_r == H - 1 && m_c == W - 1) begin
                                m_mode = 0;
                                m_done = 1'b1;
                                scan_windows = hs_count;
                            end else begin
                                m_mode = 1;
                                m_f = 0;
                                if (m_c == W - 1) begin
                                    m_c = 0;
                                    m_r++;
                                end else begin
                                    m_c++;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int n;
        bit found;
        for (int i = 0; i < W * H; i++) rom_mem[i] = DW'(i);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        win_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Latency from start edge to win_valid, then window (0,0)
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (win_valid) begin
                n = i;
                break;
            end
        end
        check("valid latency", 128'(n), 6);
        check_taps("win(0,0)", '{0, 0, 0, 0, 0, 1, 0, 64, 65});

        // Back-pressure on window (0,5)
        wait_win(0, 4, 100);
        @(posedge clk);
        #1 win_ready = 1'b0;
        wait_win(0, 5, 100);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            check("stall valid", 128'(win_valid), 1);
            check("stall tap4", 128'(win_data[4*DW +: DW]), 5);
            check("stall col", 128'(win_col), 5);
            check("stall addr1", 128'(rom_addr1), 0);
        end
        @(posedge clk);
        #1 win_ready = 1'b1;
        @(negedge clk);
        check("release valid", 128'(win_valid), 1);
        @(negedge clk);
        check("next fetch valid", 128'(win_valid), 0);
        check("next fetch busy", 128'(busy), 1);
        check("next fetch col", 128'(win_col), 6);

        // Window (1,1) addresses, with a start pulse during its fetch
        wait_win(1, 0, 500);
        @(negedge clk);
        check("(1,1) f0 addr1", 128'(rom_addr1), 0);
        check("(1,1) f0 addr2", 128'(rom_addr2), 1);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("(1,1) f4 addr1", 128'(rom_addr1), 130);
        check("(1,1) f4 addr2", 128'(rom_addr2), 0);
        @(negedge clk);
        check_taps("win(1,1)", '{0, 1, 2, 64, 65, 66, 128, 129, 130});

        // Start pulse while window (1,2) is presented and stalled
        @(posedge clk);
        #1 win_ready = 1'b0;
        wait_win(1, 2, 100);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        win_ready = 1'b1;
        @(negedge clk);
        check("start in present col", 128'(win_col), 2);

        // Last window, done pulse, and start accepted in the done cycle
        wait_win(63, 63, 30000);
        check_taps("win(63,63)", '{4030, 4031, 0, 4094, 4095, 0, 0, 0, 0});
        check("win(63,63) last", 128'(win_last), 1);
        @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        check("done pulse", 128'(done), 1);
        check("done busy", 128'(busy), 0);
        check("scan window count", 128'(scan_windows), 4096);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("done width", 128'(done), 0);
        check("restart busy", 128'(busy), 1);

        // Asynchronous reset during window (10,20) fetch f=2
        found = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            if (m_mode == 1 && m_r == 10 && m_c == 20 && m_f == 2) begin
                found = 1'b1;
                break;
            end
        end
        check("reached (10,20) f2", 128'(found), 1);
        #2 rst_n = 1'b0;
        #1 check_reset("async reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post-reset busy", 128'(busy), 0);
            check("post-reset valid", 128'(win_valid), 0);
        end

        // Fresh scan over random ROM contents with random ready and stray starts
        for (int i = 0; i < W * H; i++) rom_mem[i] = DW'($urandom);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60000; i++) begin
            @(posedge clk);
            #1;
            if (m_mode == 0 && m_done) begin
                found = 1'b1;
                win_ready = 1'b0;
                start = 1'b0;
                break;
            end
            win_ready = ($urandom_range(3) != 0);
            start = (m_mode != 0) && ($urandom_range(15) == 0);
        end
        check("random scan finished", 128'(found), 1);
        check("random scan window count", 128'(scan_windows), 4096);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
